// File: rtl/audio_rom_pwm_player.sv
// audio_rom_pwm_player
//   Streams an 8-bit clip from a sample ROM and drives it out as a PWM stream.
//   rom_addr always points one sample ahead of the sample being played.
//   The sample at that address is fetched ROM_LAT clocks into each period.
//   After LAST_ADDR, rom_addr is already at 0, so a looping clip continues
//   without a gap.
//   Optional feature: define AUDIO_PLAYER_VOL_EN to add the vol_shift
//   attenuation port.
// Ports
//   clk, reset      clock, synchronous active-low reset
//   start, stop     1-clk control pulses (stop wins)
//   loop            wrap to sample 0 after LAST_ADDR, sampled at the wrap
//   vol_shift       right shift applied to the sample (AUDIO_PLAYER_VOL_EN only)
//   rom_addr        registered ROM read address
//   rom_data        ROM read data, ROM_LAT clocks behind rom_addr
//   pwm_out         registered PWM output
//   amp_en, busy    high while playing
//   done            1-clk pulse at the natural end of a non-looping clip
module audio_rom_pwm_player #(
  parameter int                SAMPLE_W       = 8,
  parameter int                ADDR_W         = 17,
  parameter logic [ADDR_W-1:0] LAST_ADDR      = {ADDR_W{1'b1}},
  parameter int                CLK_PER_SAMPLE = 2048,
  parameter int                ROM_LAT        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
`ifdef AUDIO_PLAYER_VOL_EN
  input  logic [1:0]          vol_shift,
`endif
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic                pwm_out,
  output logic                amp_en,
  output logic                busy,
  output logic                done
);

  localparam int DIV_W  = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int PCNT_W = $clog2(ROM_LAT + 2);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, FINISH} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] cur_sample, next_sample, pwm_cnt, cmp_sample;
  logic [DIV_W-1:0]    div_cnt;
  logic [PCNT_W-1:0]   prime_cnt;
  logic                last_play;   // cur_sample is the LAST_ADDR sample
  logic                period_end;

  assign period_end = (div_cnt == DIV_W'(CLK_PER_SAMPLE - 1));
  assign amp_en     = busy;

`ifdef AUDIO_PLAYER_VOL_EN
  logic [1:0] vol_q;
  assign cmp_sample = cur_sample >> vol_q;
`else
  assign cmp_sample = cur_sample;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rom_addr    <= '0;
      pwm_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cur_sample  <= '0;
      next_sample <= '0;
      div_cnt     <= '0;
      pwm_cnt     <= '0;
      prime_cnt   <= '0;
      last_play   <= 1'b0;
`ifdef AUDIO_PLAYER_VOL_EN
      vol_q       <= '0;
`endif
    end else begin
      done    <= 1'b0;
      pwm_cnt <= busy ? pwm_cnt + 1'b1 : '0;
      pwm_out <= busy && (pwm_cnt < cmp_sample);
      case (state)
        IDLE: begin
          if (start && !stop) begin
            rom_addr   <= '0;
            busy       <= 1'b1;
            prime_cnt  <= '0;
            cur_sample <= '0;  // keep PWM low until the first sample is loaded
            state      <= PRIME;
          end
        end
        PRIME: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pwm_out  <= 1'b0;
            rom_addr <= '0;
          end else begin
            prime_cnt <= prime_cnt + 1'b1;
            if (prime_cnt == PCNT_W'(ROM_LAT)) begin
              next_sample <= rom_data;
              rom_addr    <= (LAST_ADDR == '0) ? '0 : ADDR_W'(1);
            end
            if (prime_cnt == PCNT_W'(ROM_LAT + 1)) begin
              cur_sample <= next_sample;
              div_cnt    <= '0;
              last_play  <= (LAST_ADDR == '0);
`ifdef AUDIO_PLAYER_VOL_EN
              vol_q      <= vol_shift;
`endif
              state      <= PLAY;
            end
          end
        end
        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pwm_out  <= 1'b0;
            rom_addr <= '0;
            div_cnt  <= '0;
          end else begin
            div_cnt <= period_end ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_W'(ROM_LAT))
              next_sample <= rom_data;
            if (period_end) begin
              if (last_play && !loop) begin
                state    <= FINISH;
                done     <= 1'b1;
                busy     <= 1'b0;
                pwm_out  <= 1'b0;
                rom_addr <= '0;
              end else begin
                cur_sample <= next_sample;
`ifdef AUDIO_PLAYER_VOL_EN
                vol_q      <= vol_shift;
`endif
                // rom_addr is one ahead: seeing LAST_ADDR here means the
                // sample just loaded is the last one of the clip
                last_play  <= (rom_addr == LAST_ADDR);
                rom_addr   <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
              end
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rom_pwm_player.sv
// Testbench for audio_rom_pwm_player (LAST_ADDR=3, CLK_PER_SAMPLE=16, ROM_LAT=1).
// Ports: none; drives clk/reset/start/stop/loop and models a 1-clock ROM.
module tb_audio_rom_pwm_player;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [1:0]  vol_shift = 2'd0;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pwm_out, amp_en, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rom [4] = '{8'h00, 8'h40, 8'hFF, 8'h80};

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

  audio_rom_pwm_player #(
    .SAMPLE_W(8), .ADDR_W(17), .LAST_ADDR(17'd3), .CLK_PER_SAMPLE(16), .ROM_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
`ifdef AUDIO_PLAYER_VOL_EN
    .vol_shift(vol_shift),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .pwm_out(pwm_out),
    .amp_en(amp_en), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, st, sp, lp;
    logic        busy, done, pwm;
    logic [16:0] addr;
    string       name;
  } vec_t;

  // One start pulse, then t edges of playback compared against the timing
  // model: sample k is loaded at edge 3+16k; rom_addr leads by one sample.
  task automatic run_clip(input int loops, input int stop_at, input int start_at, input string tag);
    int end_t, mb, md, ma, mp;
    logic eb, ed, ep;
    logic [16:0] ea;
    end_t = 3 + 64 * (loops + 1);
    mb = 0; md = 0; ma = 0; mp = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".start_busy"}, {31'd0, busy}, 32'd1);
    for (int t = 1; t <= end_t + 2; t++) begin
      stop  = (t == stop_at);
      start = (t == start_at);
      loop  = (t < end_t);
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
      ea = 17'd0;
      if (stop_at != 0 && t >= stop_at) begin
        eb = 1'b0; ed = 1'b0; ep = 1'b0;
      end else if (t >= end_t) begin
        eb = 1'b0; ed = (t == end_t); ep = 1'b0;
      end else begin
        eb = 1'b1; ed = 1'b0;
        if (t < 2)       ea = 17'd0;
        else if (t == 2) ea = 17'd1;
        else             ea = 17'(((t - 3) / 16 + 1) % 4);
        ep = (t < 4) ? 1'b0 : (int'(rom[((t - 4) / 16) % 4]) > ((t - 1) % 256));
      end
      if (busy !== eb || amp_en !== eb) mb++;
      if (done !== ed) md++;
      if (pwm_out !== ep) mp++;
      if (!(stop_at != 0 && t >= stop_at) && rom_addr !== ea) ma++;
    end
    loop = 1'b0;
    chk({tag, ".busy_mismatch_clks"}, mb, 0);
    chk({tag, ".done_mismatch_clks"}, md, 0);
    chk({tag, ".pwm_mismatch_clks"},  mp, 0);
    chk({tag, ".addr_mismatch_clks"}, ma, 0);
  endtask

  vec_t vec [10];

  initial begin
    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "reset1"};
    vec[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "reset2"};
    vec[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "idle"};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "start_stop_idle"};
    vec[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "idle_after"};
    vec[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0, "start"};
    vec[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0, "prime_start_ign"};
    vec[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'd1, "prime_capture"};
    vec[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'd1, "play_entry"};
    vec[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, "reset_in_prime"};

    for (int i = 0; i < 10; i++) begin
      reset = vec[i].rst_n; start = vec[i].st; stop = vec[i].sp; loop = vec[i].lp;
      @(posedge clk); #1;
      chk({vec[i].name, ".busy"},   {31'd0, busy},    {31'd0, vec[i].busy});
      chk({vec[i].name, ".amp_en"}, {31'd0, amp_en},  {31'd0, vec[i].busy});
      chk({vec[i].name, ".done"},   {31'd0, done},    {31'd0, vec[i].done});
      chk({vec[i].name, ".pwm"},    {31'd0, pwm_out}, {31'd0, vec[i].pwm});
      chk({vec[i].name, ".addr"},   {15'd0, rom_addr}, {15'd0, vec[i].addr});
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    @(posedge clk); #1;

    run_clip(0, 0, 0, "clip");
    run_clip(2, 0, 0, "loop");
    run_clip(0, 25, 0, "stop_addr2");
    run_clip(0, 0, 40, "start_busy");

    // reset in the middle of PLAY
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("midplay_reset.busy",   {31'd0, busy},    32'd0);
    chk("midplay_reset.amp_en", {31'd0, amp_en},  32'd0);
    chk("midplay_reset.pwm",    {31'd0, pwm_out}, 32'd0);
    chk("midplay_reset.done",   {31'd0, done},    32'd0);
    chk("midplay_reset.addr",   {15'd0, rom_addr}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_clip(0, 0, 0, "replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
